// File: rtl/eth_tx_pkt_gen.sv
// rtl/eth_tx_pkt_gen.sv - Ethernet test-frame generator on the MAC transmit AXI-Stream port
module eth_tx_pkt_gen #(
   parameter int          LEN_W     = 11,
   parameter int          CNT_W     = 16,
   parameter logic [47:0] DST_MAC   = 48'hffff_ffff_ffff,
   parameter logic [47:0] SRC_MAC   = 48'h0000_0000_0000,
   parameter logic [15:0] ETHERTYPE = 16'hebeb
) (
   input  logic             i_clk_mac,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [LEN_W-1:0] i_pkt_len,
   input  logic [CNT_W-1:0] i_pkt_num,
   input  logic [CNT_W-1:0] i_gap,
   input  logic [1:0]       i_mode,
   input  logic [7:0]       i_fill,
   output logic [7:0]       o_tx_axis_mac_tdata,
   output logic             o_tx_axis_mac_tvalid,
   output logic             o_tx_axis_mac_tlast,
   input  logic             i_tx_axis_mac_tready,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_sent_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(60);
   localparam logic [LEN_W-1:0] PAY_IDX  = LEN_W'(14);
   localparam logic [111:0]     HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

   state_t           r_state, w_state_nxt;
   logic [LEN_W-1:0] r_idx, w_idx_nxt, r_len, w_len_nxt;
   logic [CNT_W-1:0] r_num, w_num_nxt, r_gap, w_gap_nxt, r_gap_cnt, w_gap_cnt_nxt;
   logic [CNT_W-1:0] r_sent, w_sent_nxt;
   logic [1:0]       r_mode, w_mode_nxt;
   logic [7:0]       r_fill, w_fill_nxt, r_lfsr, w_lfsr_nxt;
   logic [7:0]       r_tdata, w_tdata_nxt;
   logic             r_tvalid, w_tvalid_nxt, r_tlast, w_tlast_nxt;
   logic             r_busy, w_busy_nxt, r_done, w_done_nxt, r_pend, w_pend_nxt;

   logic             w_fire;
   logic [CNT_W-1:0] w_sent_inc;
   logic [LEN_W-1:0] w_idx_inc;
   logic [7:0]       w_lfsr_adv;

   assign w_fire     = r_tvalid & i_tx_axis_mac_tready;
   assign w_sent_inc = r_sent + 1'b1;
   assign w_idx_inc  = r_idx + 1'b1;
   assign w_lfsr_adv = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

   // Byte at index idx: fixed header first, then the selected payload pattern
   function automatic logic [7:0] f_byte(input logic [LEN_W-1:0] idx, input logic [1:0] mode,
                                         input logic [7:0] fill, input logic [7:0] lfsr,
                                         input logic [CNT_W-1:0] seq);
      logic [111:0] sh;
      sh = '0;
      if (idx < PAY_IDX) begin
         sh = HDR >> (8 * (13 - int'(idx)));
         return sh[7:0];
      end
      case (mode)
         2'd0:    return idx[7:0];
         2'd1:    return fill;
         2'd2:    return lfsr;
         default: return seq[7:0];
      endcase
   endfunction

   // State register
   always_ff @(posedge i_clk_mac or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state, frame sequencing and next registered outputs
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_len_nxt     = r_len;
      w_num_nxt     = r_num;
      w_gap_nxt     = r_gap;
      w_mode_nxt    = r_mode;
      w_fill_nxt    = r_fill;
      w_lfsr_nxt    = r_lfsr;
      w_gap_cnt_nxt = r_gap_cnt;
      w_pend_nxt    = r_pend;
      w_sent_nxt    = r_sent;
      w_tdata_nxt   = r_tdata;
      w_tvalid_nxt  = r_tvalid;
      w_tlast_nxt   = r_tlast;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_len_nxt    = (i_pkt_len < MIN_LEN) ? MIN_LEN : i_pkt_len;
               w_num_nxt    = i_pkt_num;
               w_gap_nxt    = i_gap;
               w_mode_nxt   = i_mode;
               w_fill_nxt   = i_fill;
               w_sent_nxt   = '0;
               w_pend_nxt   = 1'b0;
               w_busy_nxt   = 1'b1;
               w_idx_nxt    = '0;
               w_lfsr_nxt   = 8'hff;
               w_tdata_nxt  = f_byte('0, i_mode, i_fill, 8'hff, '0);
               w_tvalid_nxt = 1'b1;
               w_tlast_nxt  = 1'b0;
               w_state_nxt  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (i_abort) w_pend_nxt = 1'b1;
            if (w_fire) begin
               if (r_tlast) begin
                  w_sent_nxt = w_sent_inc;
                  if (((r_num != '0) && (w_sent_inc == r_num)) || r_pend || i_abort) begin
                     w_state_nxt  = ST_IDLE;
                     w_tdata_nxt  = '0;
                     w_tvalid_nxt = 1'b0;
                     w_tlast_nxt  = 1'b0;
                     w_busy_nxt   = 1'b0;
                     w_done_nxt   = 1'b1;
                     w_pend_nxt   = 1'b0;
                  end else if (r_gap == '0) begin
                     w_idx_nxt   = '0;
                     w_lfsr_nxt  = 8'hff;
                     w_tdata_nxt = f_byte('0, r_mode, r_fill, 8'hff, w_sent_inc);
                     w_tlast_nxt = 1'b0;
                  end else begin
                     w_state_nxt   = ST_GAP;
                     w_gap_cnt_nxt = r_gap - 1'b1;
                     w_tdata_nxt   = '0;
                     w_tvalid_nxt  = 1'b0;
                     w_tlast_nxt   = 1'b0;
                  end
               end else begin
                  w_idx_nxt   = w_idx_inc;
                  w_lfsr_nxt  = (r_idx >= PAY_IDX) ? w_lfsr_adv : r_lfsr;
                  w_tdata_nxt = f_byte(w_idx_inc, r_mode, r_fill, w_lfsr_nxt, r_sent);
                  w_tlast_nxt = (w_idx_inc == r_len - 1'b1);
               end
            end
         end
         ST_GAP: begin
            if (i_abort) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_pend_nxt  = 1'b0;
            end else if (r_gap_cnt == '0) begin
               w_state_nxt  = ST_SEND;
               w_idx_nxt    = '0;
               w_lfsr_nxt   = 8'hff;
               w_tdata_nxt  = f_byte('0, r_mode, r_fill, 8'hff, r_sent);
               w_tvalid_nxt = 1'b1;
               w_tlast_nxt  = 1'b0;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge i_clk_mac or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx     <= '0;
         r_len     <= MIN_LEN;
         r_num     <= '0;
         r_gap     <= '0;
         r_mode    <= '0;
         r_fill    <= '0;
         r_lfsr    <= 8'hff;
         r_gap_cnt <= '0;
         r_pend    <= 1'b0;
         r_sent    <= '0;
         r_tdata   <= '0;
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_idx     <= w_idx_nxt;
         r_len     <= w_len_nxt;
         r_num     <= w_num_nxt;
         r_gap     <= w_gap_nxt;
         r_mode    <= w_mode_nxt;
         r_fill    <= w_fill_nxt;
         r_lfsr    <= w_lfsr_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
         r_pend    <= w_pend_nxt;
         r_sent    <= w_sent_nxt;
         r_tdata   <= w_tdata_nxt;
         r_tvalid  <= w_tvalid_nxt;
         r_tlast   <= w_tlast_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign o_tx_axis_mac_tdata  = r_tdata;
   assign o_tx_axis_mac_tvalid = r_tvalid;
   assign o_tx_axis_mac_tlast  = r_tlast;
   assign o_busy               = r_busy;
   assign o_done               = r_done;
   assign o_sent_cnt           = r_sent;

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// tb/tb_eth_tx_pkt_gen.sv - self-checking bench for eth_tx_pkt_gen
module tb_eth_tx_pkt_gen;

   localparam int LEN_W = 11;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n, start, abort, tready;
   logic [LEN_W-1:0] pkt_len;
   logic [CNT_W-1:0] pkt_num, gap;
   logic [1:0]       mode;
   logic [7:0]       fill;
   logic [7:0]       tdata;
   logic             tvalid, tlast, busy, done;
   logic [CNT_W-1:0] sent_cnt;

   always #5 clk = ~clk;

   eth_tx_pkt_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .i_clk_mac(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_pkt_len(pkt_len), .i_pkt_num(pkt_num), .i_gap(gap), .i_mode(mode), .i_fill(fill),
      .o_tx_axis_mac_tdata(tdata), .o_tx_axis_mac_tvalid(tvalid), .o_tx_axis_mac_tlast(tlast),
      .i_tx_axis_mac_tready(tready), .o_busy(busy), .o_done(done), .o_sent_cnt(sent_cnt)
   );

   typedef struct {
      int len; int num; int gap; int mode; int fill; int pct;
      int ab_frame; int ab_beat; int exp_frames;
   } tcase_t;

   typedef struct { logic [7:0] d; logic l; } beat_t;

   tcase_t tc[8];
   beat_t  q[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Expected byte stream for a whole run, pushed before stimulus starts
   task automatic push_frames(input tcase_t t);
      int         l;
      logic [7:0] lf, b;
      l = (t.len < 60) ? 60 : t.len;
      for (int f = 0; f < t.exp_frames; f++) begin
         lf = 8'hff;
         for (int i = 0; i < l; i++) begin
            if (i < 6)       b = 8'hff;
            else if (i < 12) b = 8'h00;
            else if (i < 14) b = 8'heb;
            else begin
               case (t.mode)
                  0:       b = 8'(i);
                  1:       b = 8'(t.fill);
                  2:       begin b = lf; lf = lfsr_step(lf); end
                  default: b = 8'(f);
               endcase
            end
            q.push_back('{d: b, l: (i == l - 1)});
         end
      end
   endtask

   task automatic cfg(input tcase_t t);
      pkt_len = LEN_W'(t.len);
      pkt_num = CNT_W'(t.num);
      gap     = CNT_W'(t.gap);
      mode    = 2'(t.mode);
      fill    = 8'(t.fill);
   endtask

   task automatic run(input tcase_t t, input string name);
      int         frame, beat, idle, cycles;
      bit         stall, after_last, got_done;
      logic [7:0] pd;
      logic       pl;
      beat_t      e;
      frame = 0; beat = 0; idle = 0; cycles = 0;
      stall = 0; after_last = 0; got_done = 0; pd = '0; pl = 1'b0;
      q.delete();
      push_frames(t);
      @(negedge clk);
      cfg(t);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_busy_start"}, busy, 1'b1);
      chk({name, "_tvalid_start"}, tvalid, 1'b1);
      while (!got_done && cycles < 20000) begin
         tready = ($urandom_range(99) < t.pct);
         abort  = (frame == t.ab_frame) && (beat == t.ab_beat) && tvalid;
         if (stall) begin
            chk({name, "_stall_tvalid"}, tvalid, 1'b1);
            chk({name, "_stall_tdata"}, tdata, pd);
            chk({name, "_stall_tlast"}, tlast, pl);
         end
         if (after_last) begin
            chk({name, "_sent_cnt"}, sent_cnt, frame);
            after_last = 0;
         end
         if (done) begin
            got_done = 1;
            chk({name, "_done_busy"}, busy, 1'b0);
            chk({name, "_done_tvalid"}, tvalid, 1'b0);
            chk({name, "_done_left"}, q.size(), 0);
            chk({name, "_done_sent"}, sent_cnt, t.exp_frames);
         end else if (tvalid) begin
            if (beat == 0 && frame > 0) chk({name, "_gap"}, idle, t.gap);
            idle = 0;
            if (tready) begin
               if (q.size() == 0) begin
                  chk({name, "_extra_beat"}, 1, 0);
               end else begin
                  e = q.pop_front();
                  chk({name, "_tdata"}, tdata, e.d);
                  chk({name, "_tlast"}, tlast, e.l);
               end
               beat++;
               if (tlast) begin
                  frame++;
                  beat = 0;
                  after_last = 1;
               end
            end
         end else begin
            if (beat != 0) chk({name, "_tvalid_drop"}, tvalid, 1'b1);
            idle++;
         end
         stall = tvalid && !tready;
         pd = tdata;
         pl = tlast;
         @(negedge clk);
         cycles++;
      end
      if (!got_done) chk({name, "_timeout"}, 0, 1);
      abort  = 1'b0;
      tready = 1'b1;
   endtask

   initial begin
      int n;
      tc[0] = '{64, 1, 0, 0, 0, 100, -1, 0, 1};
      tc[1] = '{64, 1, 0, 0, 0, 50, -1, 0, 1};
      tc[2] = '{64, 3, 5, 0, 0, 100, -1, 0, 3};
      tc[3] = '{64, 3, 0, 0, 0, 100, -1, 0, 3};
      tc[4] = '{64, 2, 0, 2, 0, 70, -1, 0, 2};
      tc[5] = '{64, 3, 2, 3, 0, 60, -1, 0, 3};
      tc[6] = '{20, 1, 0, 1, 8'ha5, 100, -1, 0, 1};
      tc[7] = '{20, 0, 3, 0, 0, 80, 1, 30, 2};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; tready = 1'b1;
      cfg(tc[0]);
      repeat (3) @(negedge clk);
      chk("rst_tdata", tdata, 8'h00);
      chk("rst_tvalid", tvalid, 1'b0);
      chk("rst_tlast", tlast, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sent", sent_cnt, 0);
      rst_n = 1'b1;

      for (int k = 0; k < 8; k++) run(tc[k], $sformatf("case%0d", k));

      // abort while idle must not leak into the next run
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_busy", busy, 1'b0);
      run(tc[2], "after_idle_abort");

      // abort during the inter-frame gap ends the run on the next cycle
      @(negedge clk);
      cfg('{60, 0, 20, 0, 0, 100, -1, 0, 0});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(tvalid && tlast) && n < 200) begin @(negedge clk); n++; end
      chk("gap_abort_reach_last", tvalid && tlast, 1'b1);
      @(negedge clk);
      chk("gap_abort_in_gap", tvalid, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("gap_abort_done", done, 1'b1);
      chk("gap_abort_busy", busy, 1'b0);
      chk("gap_abort_sent", sent_cnt, 1);
      @(negedge clk);
      chk("gap_abort_done_pulse", done, 1'b0);

      // asynchronous reset mid-frame, then a clean frame from byte 0
      cfg(tc[0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 10) begin @(negedge clk); n++; end
      chk("mid_rst_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tdata", tdata, 8'h00);
      chk("mid_rst_tvalid", tvalid, 1'b0);
      chk("mid_rst_tlast", tlast, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_sent", sent_cnt, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(tc[0], "after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
